div32_iterative: RTL and testbench

Sequential 32-bit integer divider serving the RISC-V M-extension DIV/DIVU/REM/REMU operations; it is the division counterpart to the pipelined 32x32 multiplier in the integer-multiply unit. One operand pair is accepted per operation through a start/done handshake. Radix-2 restoring division runs one quotient bit per clock. Quotient and remainder are both returned, with RISC-V semantics for divide-by-zero and signed overflow. It sits beside the multiplier in the execute stage.

---
 rtl/div32_iterative.sv | 218 +++++++++++++++++++++
 tb/tb_div32_iterative.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div32_iterative.sv
// ---------------------------------------------------------------------------
// div32_iterative
//   Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU. One quotient
//   bit is resolved per clock. The datapath works on magnitudes. Signs are
//   re-applied in a final fix-up cycle. Divide-by-zero and signed overflow
//   are resolved at request time and skip the iteration loop.
//   All state updates on the falling edge of clk_i, matching the multiplier
//   pipeline registers that sit beside this block.
//
// Ports
//   clk_i          clock (falling-edge active)
//   rst_n_i        asynchronous active-low reset
//   start_i        request, sampled only while idle
//   signed_div_i   1 = two's-complement operands, 0 = unsigned
//   X, Y           dividend / divisor, sampled with start_i
//   busy_o         operation in progress (DIV or FIX)
//   done_o         one-cycle pulse, results valid from this cycle
//   quotient_o     quotient, truncated toward zero
//   remainder_o    remainder, sign follows the dividend
//
// state | meaning
// IDLE  | waiting for start_i; special cases preload the result here
// DIV   | one shift/trial-subtract step per edge, OPERAND_SIZE steps
// FIX   | apply signs, register results, pulse done_o
// ---------------------------------------------------------------------------
module div32_iterative #(
  parameter int OPERAND_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    signed_div_i,
  input  logic [OPERAND_SIZE-1:0] X,
  input  logic [OPERAND_SIZE-1:0] Y,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [OPERAND_SIZE-1:0] quotient_o,
  output logic [OPERAND_SIZE-1:0] remainder_o
);

  localparam int N     = OPERAND_SIZE;
  localparam int CNT_W = $clog2(OPERAND_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPERAND_SIZE - 1);
  localparam logic [N-1:0]     MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     rem_q, rem_d;      // partial remainder
  logic [N-1:0]     dvd_q, dvd_d;      // dividend, becomes quotient as it shifts
  logic [N-1:0]     dvs_q, dvs_d;      // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [N-1:0]     quo_out_q, quo_out_d;
  logic [N-1:0]     rem_out_q, rem_out_d;
  logic             done_q, done_d;

  logic             x_neg, y_neg;
  logic [N-1:0]     x_mag, y_mag;
  logic             div_by_zero, overflow, special;
  logic [N:0]       trial;

  // Operand preconditioning. The magnitude of the most negative value is
  // the same bit pattern read as unsigned, which the unsigned datapath
  // handles without extra logic.
  assign x_neg       = signed_div_i & X[N-1];
  assign y_neg       = signed_div_i & Y[N-1];
  assign x_mag       = x_neg ? (~X + 1'b1) : X;
  assign y_mag       = y_neg ? (~Y + 1'b1) : Y;
  assign div_by_zero = (Y == '0);
  assign overflow    = signed_div_i & (X == MIN_NEG) & (Y == '1);
  assign special     = div_by_zero | overflow;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in N+1 bits. A set top bit of the difference means "negative".
  assign trial = {rem_q, dvd_q[N-1]} - {1'b0, dvs_q};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = special ? S_FIX : S_DIV;
        end
      end
      S_DIV: begin
        if (count_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy_o      = (state_q == S_DIV) || (state_q == S_FIX);
    done_o      = done_q;
    quotient_o  = quo_out_q;
    remainder_o = rem_out_q;
  end

  // -------------------------------------------------------------------------
  // Datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    count_d   = count_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          count_d = '0;
          if (div_by_zero) begin
            // Preloaded as final values; clearing the sign flags makes FIX
            // pass them through untouched.
            dvd_d     = '1;
            rem_d     = X;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else if (overflow) begin
            dvd_d     = MIN_NEG;
            rem_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            dvd_d     = x_mag;
            dvs_d     = y_mag;
            rem_d     = '0;
            neg_quo_d = x_neg ^ y_neg;
            neg_rem_d = x_neg;
          end
        end
      end
      S_DIV: begin
        count_d = count_q + CNT_W'(1);
        if (!trial[N]) begin
          rem_d = trial[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[N-2:0], dvd_q[N-1]};
          dvd_d = {dvd_q[N-2:0], 1'b0};
        end
      end
      S_FIX: begin
        count_d   = '0;
        quo_out_d = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_out_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        done_d    = 1'b1;
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q   <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_div32_iterative.sv
// Bench for div32_iterative. The DUT updates on the falling edge; inputs are
// driven and outputs sampled on the rising edge.
module tb_div32_iterative;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div32_iterative #(.OPERAND_SIZE(32)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .signed_div_i (sgn),
    .X            (x_in),
    .Y            (y_in),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quo),
    .remainder_o  (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    if (y == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      e.q = 32'($signed(x) / $signed(y));
      e.r = 32'($signed(x) % $signed(y));
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    return e;
  endfunction

  // Called at a rising edge; the request is sampled on the next falling edge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    sb.push_back(e);
    x_in  = x;
    y_in  = y;
    sgn   = s;
    start = 1'b1;
  endtask

  // n counts falling edges starting with the one that samples the request.
  // Returns at the rising edge inside the done_o cycle.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input int inj_edge);
    int   n;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    n        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      @(posedge clk);
      if (n == 1) start = 1'b0;
      if (inj_edge > 0 && n == inj_edge - 1) begin
        start = 1'b1;
        x_in  = 32'd9;
        y_in  = 32'd3;
        sgn   = 1'b0;
      end
      if (inj_edge > 0 && n == inj_edge) start = 1'b0;
      check({tag, "_busy_done_excl"}, {31'd0, busy & done}, 32'd0);
      if (done) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        if (sb.size() == 0) begin
          check({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, "_quotient"}, quo, e.q);
          check({tag, "_remainder"}, rem, e.r);
          last_q = e.q;
          last_r = e.r;
        end
      end else if (busy) begin
        busy_cnt++;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  // One cycle after done_o: pulse gone, idle, results held.
  task automatic idle_check(input string tag);
    @(negedge clk);
    @(posedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold_q"}, quo, last_q);
    check({tag, "_hold_r"}, rem, last_r);
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rs;
    exp_t        me;

    rst_n = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quo, 32'd0);
    check("rst_r", rem, 32'd0);
    rst_n = 1'b1;

    // Request in the first idle cycle after reset release.
    launch(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    wait_done("u100_7", 34, 33, 0);
    idle_check("u100_7");

    launch(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    wait_done("s_m7_2", 34, 33, 0);
    idle_check("s_m7_2");

    launch(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done("s_div0", 2, 1, 0);
    idle_check("s_div0");

    launch(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done("u_div0", 2, 1, 0);
    idle_check("u_div0");

    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    wait_done("s_ovf", 2, 1, 0);
    idle_check("s_ovf");

    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    wait_done("u_ovf", 34, 33, 0);
    idle_check("u_ovf");

    // Start pulse while busy is ignored; then back-to-back from the done cycle.
    launch(32'd50, 32'd5, 1'b0, 32'd10, 32'd0);
    wait_done("ign_busy", 34, 33, 10);
    launch(32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
    wait_done("b2b", 34, 33, 0);
    idle_check("b2b");

    launch(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    wait_done("s_7_m2", 34, 33, 0);

    launch(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    wait_done("u_max_1", 34, 33, 0);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 28);
      rs = (i % 2) == 1;
      me = model(rx, ry, rs);
      launch(rx, ry, rs, me.q, me.r);
      wait_done("rand", (ry == 32'd0) ? 2 : 34, (ry == 32'd0) ? 1 : 33, 0);
    end

    // Reset in the middle of an operation.
    @(posedge clk);
    x_in  = 32'd1000;
    y_in  = 32'd3;
    sgn   = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      @(posedge clk);
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q", quo, 32'd0);
    check("abort_r", rem, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    launch(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE);
    wait_done("s_m100_m7", 34, 33, 0);
    idle_check("s_m100_m7");

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
